// File: rtl/sweep_ctrl_pkg.sv
// sweep_ctrl_pkg: state encoding and default widths shared by the sweep controller and its interface.
package sweep_ctrl_pkg;
  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_CLEAR = 3'd1;
  localparam logic [2:0] ST_UP = 3'd2;
  localparam logic [2:0] ST_DOWN = 3'd3;
  localparam logic [2:0] ST_DONE = 3'd4;
  localparam int SWEEP_W = 4;
  localparam int SWEEP_REPS_W = 4;
  typedef enum logic [2:0] {
    S_IDLE = ST_IDLE,
    S_CLEAR = ST_CLEAR,
    S_UP = ST_UP,
    S_DOWN = ST_DOWN,
    S_DONE = ST_DONE
  } state_e;
endpackage

// File: rtl/updown_sweep_ctrl_if.sv
// updown_sweep_ctrl_if: host request, counter control and status signals; abort exists only with SWEEP_CTRL_ABORT_EN.
interface updown_sweep_ctrl_if
  import sweep_ctrl_pkg::*;
#(
  parameter int W = SWEEP_W,
  parameter int REPS_W = SWEEP_REPS_W
);
  logic start;
  logic [W-1:0] lim;
  logic [REPS_W-1:0] reps;
  logic [W-1:0] cnt_val;
  logic [W-1:0] cnt_n;
  logic cnt_up;
  logic cnt_en;
  logic cnt_clr;
  logic busy;
  logic done;
  logic [REPS_W-1:0] sweep_cnt;
`ifdef SWEEP_CTRL_ABORT_EN
  logic abort;
  modport slave (input start, lim, reps, cnt_val, abort,
                 output cnt_n, cnt_up, cnt_en, cnt_clr, busy, done, sweep_cnt);
  modport master (output start, lim, reps, cnt_val, abort,
                  input cnt_n, cnt_up, cnt_en, cnt_clr, busy, done, sweep_cnt);
`else
  modport slave (input start, lim, reps, cnt_val,
                 output cnt_n, cnt_up, cnt_en, cnt_clr, busy, done, sweep_cnt);
  modport master (output start, lim, reps, cnt_val,
                  input cnt_n, cnt_up, cnt_en, cnt_clr, busy, done, sweep_cnt);
`endif
endinterface

// File: rtl/updown_sweep_ctrl.sv
// updown_sweep_ctrl: runs reps triangle sweeps (0..lim..0) on an external up/down counter.
// Optional abort input enabled by defining SWEEP_CTRL_ABORT_EN.
module updown_sweep_ctrl
  import sweep_ctrl_pkg::*;
#(
  parameter int W = SWEEP_W,
  parameter int REPS_W = SWEEP_REPS_W
) (
  input logic clk,
  input logic reset,
  updown_sweep_ctrl_if.slave bus
);
  state_e st_q, st_d;
  logic [W-1:0] lim_q, lim_d;
  logic [REPS_W-1:0] reps_q, reps_d, sweep_q, sweep_d;
  logic dir_q, peak, zero, ab;
  assign peak = bus.cnt_val >= lim_q;
  assign zero = bus.cnt_val == '0;
`ifdef SWEEP_CTRL_ABORT_EN
  assign ab = bus.abort && (st_q == S_CLEAR || st_q == S_UP || st_q == S_DOWN);
`else
  assign ab = 1'b0;
`endif
  always_comb begin
    st_d = st_q;
    lim_d = lim_q;
    reps_d = reps_q;
    sweep_d = sweep_q;
    case (st_q)
      S_IDLE: if (bus.start) begin
        st_d = S_CLEAR;
        lim_d = bus.lim;
        reps_d = bus.reps;
        sweep_d = '0;
      end
      S_CLEAR: st_d = (reps_q == '0) ? S_DONE : S_UP;
      S_UP: st_d = peak ? S_DOWN : S_UP;
      S_DOWN: if (zero) begin
        sweep_d = sweep_q + 1'b1;
        st_d = (sweep_d == reps_q) ? S_DONE : S_UP;
      end
      default: st_d = S_IDLE;
    endcase
    if (ab) begin
      st_d = S_IDLE;
      sweep_d = sweep_q;
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      st_q <= S_IDLE;
      lim_q <= '0;
      reps_q <= '0;
      sweep_q <= '0;
      dir_q <= 1'b0;
    end else begin
      st_q <= st_d;
      lim_q <= lim_d;
      reps_q <= reps_d;
      sweep_q <= sweep_d;
      dir_q <= bus.cnt_up;
    end
  end
  // direction is forced in UP/DOWN and otherwise holds whatever it last was
  assign bus.cnt_up = (st_q == S_UP) || (st_q != S_DOWN && dir_q);
  assign bus.cnt_en = (st_q == S_UP) ? !peak : (st_q == S_DOWN) ? !zero : 1'b0;
  assign bus.cnt_clr = (st_q == S_CLEAR) || ab;
  assign bus.busy = st_q != S_IDLE;
  assign bus.done = st_q == S_DONE;
  assign bus.cnt_n = lim_q;
  assign bus.sweep_cnt = sweep_q;
endmodule

// File: tb/tb_updown_sweep_ctrl.sv
// tb_updown_sweep_ctrl: directed checks of the sweep controller driving a behavioural up/down counter.
module tb_updown_sweep_ctrl;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int checks = 0;
  int errors = 0;
  updown_sweep_ctrl_if #(.W(4), .REPS_W(4)) bus ();
  updown_sweep_ctrl #(.W(4), .REPS_W(4)) dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  always @(posedge clk) begin
    if (reset || bus.cnt_clr) bus.cnt_val <= '0;
    else if (bus.cnt_en) bus.cnt_val <= bus.cnt_up ? bus.cnt_val + 4'd1 : bus.cnt_val - 4'd1;
  end
  task automatic run_until_done(input int budget, output int cyc, output int en_hi, output int clr_n);
    cyc = 0;
    en_hi = 0;
    clr_n = 0;
    do begin
      @(negedge clk);
      bus.start = 1'b0;
      cyc++;
      if (bus.cnt_en) en_hi++;
      if (bus.cnt_clr) clr_n++;
    end while (!bus.done && cyc < budget);
  endtask
  task automatic test_reset;
    reset = 1'b1;
    bus.start = 1'b1;
    bus.lim = 4'd5;
    bus.reps = 4'd2;
    repeat (2) @(negedge clk);
    checks++;
    if ({bus.busy, bus.done, bus.cnt_up, bus.cnt_en, bus.cnt_clr} !== 5'b0 || bus.cnt_n !== 4'd0 || bus.sweep_cnt !== 4'd0) begin
      errors++;
      $display("FAIL reset_outputs got busy=%b done=%b up=%b en=%b clr=%b n=%0d sweep=%0d want all 0",
               bus.busy, bus.done, bus.cnt_up, bus.cnt_en, bus.cnt_clr, bus.cnt_n, bus.sweep_cnt);
    end
    reset = 1'b0;
    bus.start = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.busy !== 1'b0 || bus.cnt_n !== 4'd0) begin
      errors++;
      $display("FAIL reset_start_ignored got busy=%b n=%0d want busy=0 n=0", bus.busy, bus.cnt_n);
    end
  endtask
  task automatic test_basic;
    logic [3:0] seq [8] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd3, 4'd2, 4'd1, 4'd0};
    int j;
    bus.lim = 4'd3;
    bus.reps = 4'd2;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    checks++;
    if (bus.cnt_clr !== 1'b1 || bus.busy !== 1'b1 || bus.cnt_n !== 4'd3 || bus.cnt_en !== 1'b0) begin
      errors++;
      $display("FAIL basic_clear got clr=%b busy=%b n=%0d en=%b want 1 1 3 0", bus.cnt_clr, bus.busy, bus.cnt_n, bus.cnt_en);
    end
    for (int k = 2; k <= 17; k++) begin
      @(negedge clk);
      j = (k - 2) % 8;
      checks++;
      if (bus.cnt_val !== seq[j] || bus.cnt_en !== (j != 3 && j != 7) || bus.cnt_up !== (j < 4)
          || bus.busy !== 1'b1 || bus.done !== 1'b0 || bus.cnt_clr !== 1'b0) begin
        errors++;
        $display("FAIL basic_cycle%0d got val=%0d en=%b up=%b busy=%b done=%b clr=%b want val=%0d en=%b up=%b busy=1 done=0 clr=0",
                 k, bus.cnt_val, bus.cnt_en, bus.cnt_up, bus.busy, bus.done, bus.cnt_clr, seq[j], (j != 3 && j != 7), (j < 4));
      end
    end
    @(negedge clk);
    checks++;
    if (bus.done !== 1'b1 || bus.busy !== 1'b1 || bus.sweep_cnt !== 4'd2) begin
      errors++;
      $display("FAIL basic_done got done=%b busy=%b sweep=%0d want 1 1 2", bus.done, bus.busy, bus.sweep_cnt);
    end
    @(negedge clk);
    checks++;
    if (bus.done !== 1'b0 || bus.busy !== 1'b0 || bus.sweep_cnt !== 4'd2 || bus.cnt_up !== 1'b0 || bus.cnt_en !== 1'b0) begin
      errors++;
      $display("FAIL basic_idle got done=%b busy=%b sweep=%0d up=%b en=%b want 0 0 2 0 0",
               bus.done, bus.busy, bus.sweep_cnt, bus.cnt_up, bus.cnt_en);
    end
  endtask
  task automatic test_reps_zero;
    int cyc, en_hi, clr_n;
    bus.lim = 4'd9;
    bus.reps = 4'd0;
    bus.start = 1'b1;
    run_until_done(30, cyc, en_hi, clr_n);
    checks++;
    if (cyc !== 2 || en_hi !== 0 || clr_n !== 1 || bus.sweep_cnt !== 4'd0 || bus.done !== 1'b1) begin
      errors++;
      $display("FAIL reps_zero got cycles=%0d en=%0d clr=%0d sweep=%0d done=%b want 2 0 1 0 1",
               cyc, en_hi, clr_n, bus.sweep_cnt, bus.done);
    end
    @(negedge clk);
  endtask
  task automatic test_lim_zero;
    int cyc, en_hi, clr_n;
    bus.lim = 4'd0;
    bus.reps = 4'd3;
    bus.start = 1'b1;
    run_until_done(40, cyc, en_hi, clr_n);
    checks++;
    if (cyc !== 8 || en_hi !== 0 || clr_n !== 1 || bus.sweep_cnt !== 4'd3 || bus.done !== 1'b1) begin
      errors++;
      $display("FAIL lim_zero got cycles=%0d en=%0d clr=%0d sweep=%0d done=%b want 8 0 1 3 1",
               cyc, en_hi, clr_n, bus.sweep_cnt, bus.done);
    end
    @(negedge clk);
  endtask
  task automatic test_start_busy;
    int cyc = 0;
    int bad_n = 0;
    bus.lim = 4'd5;
    bus.reps = 4'd1;
    bus.start = 1'b1;
    do begin
      @(negedge clk);
      cyc++;
      bus.start = (cyc == 4);
      if (cyc == 4) begin
        bus.lim = 4'd7;
        bus.reps = 4'd1;
      end
      if (bus.cnt_n !== 4'd5) bad_n++;
    end while (!bus.done && cyc < 40);
    bus.start = 1'b0;
    checks++;
    if (cyc !== 14 || bad_n !== 0 || bus.sweep_cnt !== 4'd1) begin
      errors++;
      $display("FAIL start_busy got cycles=%0d bad_n=%0d sweep=%0d want 14 0 1", cyc, bad_n, bus.sweep_cnt);
    end
    @(negedge clk);
    checks++;
    if (bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL start_busy_idle got busy=%b want 0", bus.busy);
    end
  endtask
  task automatic test_reset_abort;
    int done_n = 0;
    bus.lim = 4'd4;
    bus.reps = 4'd2;
    bus.start = 1'b1;
    repeat (8) begin
      @(negedge clk);
      bus.start = 1'b0;
    end
    checks++;
    if (bus.cnt_up !== 1'b0 || bus.cnt_en !== 1'b1 || bus.cnt_val !== 4'd3 || bus.busy !== 1'b1) begin
      errors++;
      $display("FAIL reset_abort_down got up=%b en=%b val=%0d busy=%b want 0 1 3 1", bus.cnt_up, bus.cnt_en, bus.cnt_val, bus.busy);
    end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    checks++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.cnt_n !== 4'd0 || bus.cnt_en !== 1'b0 || bus.sweep_cnt !== 4'd0) begin
      errors++;
      $display("FAIL reset_abort_idle got busy=%b done=%b n=%0d en=%b sweep=%0d want 0 0 0 0 0",
               bus.busy, bus.done, bus.cnt_n, bus.cnt_en, bus.sweep_cnt);
    end
    repeat (4) begin
      @(negedge clk);
      if (bus.done || bus.busy) done_n++;
    end
    checks++;
    if (done_n !== 0) begin
      errors++;
      $display("FAIL reset_abort_quiet got active_cycles=%0d want 0", done_n);
    end
  endtask
`ifdef SWEEP_CTRL_ABORT_EN
  task automatic test_abort;
    int done_n = 0;
    bus.lim = 4'd4;
    bus.reps = 4'd2;
    bus.start = 1'b1;
    repeat (4) begin
      @(negedge clk);
      bus.start = 1'b0;
    end
    bus.abort = 1'b1;
    #1;
    checks++;
    if (bus.cnt_clr !== 1'b1 || bus.busy !== 1'b1 || bus.cnt_val !== 4'd2) begin
      errors++;
      $display("FAIL abort_clr got clr=%b busy=%b val=%0d want 1 1 2", bus.cnt_clr, bus.busy, bus.cnt_val);
    end
    @(negedge clk);
    bus.abort = 1'b0;
    checks++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.cnt_clr !== 1'b0 || bus.cnt_val !== 4'd0 || bus.cnt_up !== 1'b1) begin
      errors++;
      $display("FAIL abort_idle got busy=%b done=%b clr=%b val=%0d up=%b want 0 0 0 0 1",
               bus.busy, bus.done, bus.cnt_clr, bus.cnt_val, bus.cnt_up);
    end
    bus.abort = 1'b1;
    repeat (3) begin
      @(negedge clk);
      if (bus.done || bus.busy || bus.cnt_clr) done_n++;
    end
    bus.abort = 1'b0;
    checks++;
    if (done_n !== 0) begin
      errors++;
      $display("FAIL abort_quiet got active_cycles=%0d want 0", done_n);
    end
  endtask
`endif
  initial begin
    bus.start = 1'b0;
    bus.lim = '0;
    bus.reps = '0;
`ifdef SWEEP_CTRL_ABORT_EN
    bus.abort = 1'b0;
`endif
    test_reset();
    test_basic();
    test_reps_zero();
    test_lim_zero();
    test_start_busy();
    test_reset_abort();
`ifdef SWEEP_CTRL_ABORT_EN
    test_abort();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
